// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-stream test-pattern checker.
package axis_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RX   = 2'd1,
      ST_DONE = 2'd2
   } chk_state_t;

   localparam logic [31:0] FILL_PATTERN = 32'hDEADBEEF;

   // Fibonacci LFSR x^16 + x^14 + x^13 + x^11: taps are bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int ERR_CNT_W   = 16;
   localparam int PKT_CNT_W   = 32;
   localparam int ABORT_CNT_W = 16;

endpackage

// File: rtl/axis_count2keep.sv
// Remaining-byte count to tkeep decode: low rem bits set, all ones once rem >= W.
module axis_count2keep #(
   parameter int DATA_WIDTH = 64
) (
   input  logic [31:0]             rem_i,
   output logic [DATA_WIDTH/8-1:0] keep_o
);

   localparam int W = DATA_WIDTH / 8;

   always_comb begin
      keep_o = '0;
      for (int i = 0; i < W; i++) begin
         keep_o[i] = (rem_i > 32'(i));
      end
   end

endmodule

// File: rtl/axis_data_checker.sv
// Sink-side checker for the generator's counter pattern; one frame per start edge.
// Optional AXIS_DATA_CHECKER_BACKPRESSURE_EN gates tready with an LFSR bit.
module axis_data_checker
   import axis_chk_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [31:0]             length,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tuser,
   output logic                    busy,
   output logic                    done,
   output logic                    err_data,
   output logic                    err_last,
   output logic                    err_keep,
   output logic [ERR_CNT_W-1:0]    err_count,
   output logic [PKT_CNT_W-1:0]    pkt_count,
   output logic [ABORT_CNT_W-1:0]  abort_count
);

   localparam int W   = DATA_WIDTH / 8;
   localparam int NSL = DATA_WIDTH / 32;

   chk_state_t             state_q;
   logic                   start_q, arm_q, aborted_q;
   logic [31:0]            len_pend_q, length_q, off_q;
   logic                   done_q, err_data_q, err_last_q, err_keep_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;
   logic [PKT_CNT_W-1:0]   pkt_cnt_q;
   logic [ABORT_CNT_W-1:0] abort_cnt_q;

   logic                   rx, accept, exp_last, ab_now;
   logic                   data_bad, last_bad, keep_bad, beat_bad;
   logic [DATA_WIDTH-1:0]  exp_data;
   logic [W-1:0]           keep_dec, exp_keep;
   logic [31:0]            rem;

   assign rx = (state_q == ST_RX);

`ifdef AXIS_DATA_CHECKER_BACKPRESSURE_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end
   assign s_axis_tready = rx & lfsr_q[0];
`else
   assign s_axis_tready = rx;
`endif

   assign accept = s_axis_tvalid & s_axis_tready;

   always_comb begin
      exp_data = '0;
      for (int i = 0; i < NSL; i++) begin
         if (i == 0)      exp_data[i*32 +: 32] = off_q;
         else if (i == 1) exp_data[i*32 +: 32] = ~off_q;
         else             exp_data[i*32 +: 32] = FILL_PATTERN;
      end
   end

   // 33-bit compare so an offset near 2^32 cannot wrap into a false "last"
   assign exp_last = ({1'b0, off_q} + 33'(W)) >= {1'b0, length_q};
   assign rem      = length_q - off_q;

   axis_count2keep #(.DATA_WIDTH(DATA_WIDTH)) u_keep (
      .rem_i  (rem),
      .keep_o (keep_dec)
   );

   assign exp_keep = exp_last ? keep_dec : '1;
   assign ab_now   = aborted_q | s_axis_tuser;
   assign data_bad = (s_axis_tdata != exp_data);
   assign last_bad = ~ab_now & ((s_axis_tlast != exp_last) | (off_q >= length_q));
   assign keep_bad = ~ab_now & s_axis_tlast & exp_last & (s_axis_tkeep != exp_keep);
   assign beat_bad = data_bad | last_bad | keep_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         start_q     <= 1'b0;
         arm_q       <= 1'b0;
         len_pend_q  <= '0;
         length_q    <= '0;
         off_q       <= '0;
         aborted_q   <= 1'b0;
         done_q      <= 1'b0;
         err_data_q  <= 1'b0;
         err_last_q  <= 1'b0;
         err_keep_q  <= 1'b0;
         err_cnt_q   <= '0;
         pkt_cnt_q   <= '0;
         abort_cnt_q <= '0;
      end else begin
         start_q <= start;
         arm_q   <= start & ~start_q;
         if (start & ~start_q) len_pend_q <= length;

         if (arm_q) begin
            // Re-arm from any state; an abandoned RX frame is simply dropped
            length_q   <= len_pend_q;
            off_q      <= '0;
            aborted_q  <= 1'b0;
            err_data_q <= 1'b0;
            err_last_q <= 1'b0;
            err_keep_q <= 1'b0;
            if (len_pend_q == '0) begin
               state_q   <= ST_DONE;
               done_q    <= 1'b1;
               pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end else begin
               state_q <= ST_RX;
               done_q  <= 1'b0;
            end
         end else if (rx && accept) begin
            off_q     <= off_q + 32'(W);
            aborted_q <= ab_now;
            if (data_bad) err_data_q <= 1'b1;
            if (last_bad) err_last_q <= 1'b1;
            if (keep_bad) err_keep_q <= 1'b1;
            if (beat_bad && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
            if (s_axis_tlast) begin
               state_q   <= ST_DONE;
               done_q    <= 1'b1;
               pkt_cnt_q <= pkt_cnt_q + 32'd1;
               if (ab_now && abort_cnt_q != '1) abort_cnt_q <= abort_cnt_q + 16'd1;
            end
         end
      end
   end

   assign busy        = rx;
   assign done        = done_q;
   assign err_data    = err_data_q;
   assign err_last    = err_last_q;
   assign err_keep    = err_keep_q;
   assign err_count   = err_cnt_q;
   assign pkt_count   = pkt_cnt_q;
   assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_axis_data_checker.sv
// Randomized + directed bench for axis_data_checker against a per-frame reference model.
module tb_axis_data_checker;

   localparam int DW = 64;
   localparam int W  = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n, start;
   logic [31:0]   length;
   logic [DW-1:0] tdata;
   logic [W-1:0]  tkeep;
   logic          tvalid, tready, tlast, tuser;
   logic          busy, done, err_data, err_last, err_keep;
   logic [15:0]   err_count, abort_count;
   logic [31:0]   pkt_count;

   axis_data_checker #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .length(length),
      .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
      .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .busy(busy), .done(done), .err_data(err_data), .err_last(err_last),
      .err_keep(err_keep), .err_count(err_count), .pkt_count(pkt_count),
      .abort_count(abort_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // reference state
   longint m_pkt, m_err, m_abort;
   logic [DW-1:0] bd[$];
   logic [W-1:0]  bk[$];
   bit            bl[$], bu[$];

   function automatic logic [DW-1:0] pat(input longint off);
      logic [DW-1:0] v;
      logic [31:0]   o;
      o = 32'(off);
      for (int i = 0; i < DW/32; i++)
         v[i*32 +: 32] = (i == 0) ? o : (i == 1) ? ~o : 32'hDEADBEEF;
      return v;
   endfunction

   function automatic logic [W-1:0] low_mask(input longint n);
      logic [W-1:0] m;
      for (int i = 0; i < W; i++) m[i] = (i < n);
      return m;
   endfunction

   task automatic build_clean(input int unsigned len);
      int nb;
      bd.delete(); bk.delete(); bl.delete(); bu.delete();
      nb = (len + W - 1) / W;
      for (int k = 0; k < nb; k++) begin
         bd.push_back(pat(k * W));
         bk.push_back((k == nb - 1) ? low_mask(len - k * W) : '1);
         bl.push_back(k == nb - 1);
         bu.push_back(1'b0);
      end
   endtask

   task automatic arm(input int unsigned len);
      @(posedge clk); #1;
      start = 1'b1; length = len;
      @(posedge clk); #1;
      chk("arm_not_ready_yet", tready, 1'b0);
      start = 1'b0; length = $urandom;
      @(posedge clk); #1;
      chk("arm_busy", busy, len != 0);
      chk("arm_tready", tready, len != 0);
   endtask

   task automatic send_beats();
      bit acc;
      int n;
      for (int k = 0; k < bd.size(); k++) begin
         tvalid = 1'b0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         tdata = bd[k]; tkeep = bk[k]; tlast = bl[k]; tuser = bu[k]; tvalid = 1'b1;
         n = 0;
         do begin
            @(negedge clk); acc = tready;
            @(posedge clk); #1; n++;
         end while (!acc && n < 200);
         if (!acc) chk("accept_timeout", 1'b0, 1'b1);
         tvalid = 1'b0;
      end
   endtask

   task automatic run_frame(input string tag, input int unsigned len);
      bit e_data, e_last, e_keep, ab, lbad, kbad, dbad, explast;
      longint off, rem, n;
      logic [W-1:0] ek;
      arm(len);
      send_beats();
      e_data = 0; e_last = 0; e_keep = 0; ab = 0;
      for (int k = 0; k < bd.size(); k++) begin
         off     = longint'(k) * W;
         ab      = ab | bu[k];
         explast = (off + W >= len);
         rem     = (longint'(len) - off) & 64'hFFFF_FFFF;
         n       = (rem >= W) ? W : rem;
         ek      = explast ? low_mask(n) : '1;
         dbad    = (bd[k] !== pat(off));
         lbad    = (bl[k] != explast) || (off >= len);
         kbad    = bl[k] && explast && (bk[k] !== ek);
         if (ab) begin lbad = 0; kbad = 0; end
         e_data |= dbad; e_last |= lbad; e_keep |= kbad;
         if ((dbad || lbad || kbad) && m_err < 16'hFFFF) m_err++;
      end
      m_pkt++;
      if (ab && m_abort < 16'hFFFF) m_abort++;
      chk({tag, "_done"},  done, 1'b1);
      chk({tag, "_busy"},  busy, 1'b0);
      chk({tag, "_data"},  err_data, e_data);
      chk({tag, "_last"},  err_last, e_last);
      chk({tag, "_keep"},  err_keep, e_keep);
      chk({tag, "_ecnt"},  err_count, m_err);
      chk({tag, "_pcnt"},  pkt_count, m_pkt & 64'hFFFF_FFFF);
      chk({tag, "_acnt"},  abort_count, m_abort);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tready"}, tready, 0);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_done"},   done, 0);
      chk({tag, "_errs"},   {err_data, err_last, err_keep}, 0);
      chk({tag, "_ecnt"},   err_count, 0);
      chk({tag, "_pcnt"},   pkt_count, 0);
      chk({tag, "_acnt"},   abort_count, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int unsigned len, nb, j, mode;
      rst_n = 1'b0; start = 1'b0; length = '0;
      tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      m_pkt = 0; m_err = 0; m_abort = 0;
      #12;
      check_zero("reset");
      @(negedge clk); rst_n = 1'b1;

      build_clean(64);            run_frame("len64_clean", 64);
      chk("len64_lastkeep", bk[7], 8'hFF);
      build_clean(20);            run_frame("len20_clean", 20);
      chk("len20_lastkeep", bk[2], 8'h0F);
      build_clean(20); bk[2] = 8'hFF; run_frame("len20_badkeep", 20);
      build_clean(32); bd[2][63:32] = ~bd[2][63:32]; run_frame("len32_flip", 32);
      build_clean(16); bl[1] = 1'b0;
      bd.push_back(pat(16)); bk.push_back('1); bl.push_back(1'b1); bu.push_back(1'b0);
      run_frame("len16_excess", 16);
      build_clean(64);
      while (bd.size() > 2) begin
         void'(bd.pop_back()); void'(bk.pop_back()); void'(bl.pop_back()); void'(bu.pop_back());
      end
      bl[1] = 1'b1; bu[1] = 1'b1;
      run_frame("len64_abort", 64);
      build_clean(0);             run_frame("len0", 0);

      for (int f = 0; f < 24; f++) begin
         len = $urandom_range(1, 100);
         build_clean(len);
         nb = bd.size();
         mode = $urandom_range(0, 4);
         case (mode)
            1: begin j = $urandom_range(0, nb - 1); bd[j][$urandom_range(0, DW - 1)] ^= 1'b1; end
            2: bk[nb - 1] = W'($urandom);
            3: if (nb > 1) begin
                  j = $urandom_range(0, nb - 2);
                  bl[j] = 1'b1;
                  while (bd.size() > j + 1) begin
                     void'(bd.pop_back()); void'(bk.pop_back());
                     void'(bl.pop_back()); void'(bu.pop_back());
                  end
               end
            4: bu[$urandom_range(0, nb - 1)] = 1'b1;
            default: ;
         endcase
         run_frame("rand", len);
      end

      // reset in the middle of a frame, while the offset-24 beat is presented
      build_clean(64);
      while (bd.size() > 3) begin
         void'(bd.pop_back()); void'(bk.pop_back()); void'(bl.pop_back()); void'(bu.pop_back());
      end
      arm(64);
      send_beats();
      tdata = pat(24); tkeep = '1; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_zero("midreset");
      @(negedge clk); tvalid = 1'b0; rst_n = 1'b1;
      m_pkt = 0; m_err = 0; m_abort = 0;
      build_clean(8);             run_frame("post_reset_len8", 8);
      chk("post_reset_pkt_is_one", pkt_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
